// File: rtl/pulse_capture_if.sv
// Signal bundle between a pulse source/consumer and pulse_capture.
// The slave side is the capture block; the master side drives enable/pulse_in and reads results.
interface pulse_capture_if #(
   parameter int CNT_W = 16
) ();
   logic             enable;
   logic             pulse_in;
   logic [CNT_W-1:0] width;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             timeout;
   logic [15:0]      meas_count;

   modport master (
      output enable, pulse_in,
      input  width, period, valid, timeout, meas_count
   );

   modport slave (
      input  enable, pulse_in,
      output width, period, valid, timeout, meas_count
   );
endinterface

// File: rtl/pulse_capture.sv
// Measures high time and rise-to-rise period of an asynchronous pulse/PWM input,
// reporting each completed cycle with a one-cycle valid strobe.
module pulse_capture #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 50000
) (
   input logic           clk,
   input logic           rst,
   pulse_capture_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_s;

   state_t                 r_state,      w_state_nxt;
   logic [CNT_W-1:0]       r_w_cnt,      w_w_cnt_nxt;
   logic [CNT_W-1:0]       r_p_cnt,      w_p_cnt_nxt;
   logic [CNT_W-1:0]       r_width,      w_width_nxt;
   logic [CNT_W-1:0]       r_period,     w_period_nxt;
   logic                   r_valid,      w_valid_nxt;
   logic                   r_timeout,    w_timeout_nxt;
   logic [15:0]            r_meas_count, w_meas_count_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   // Synchronizer, then registered edge flags so every FSM input comes straight from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_s_d  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pulse_in};
         r_s_d  <= w_s;
         r_rise <= w_s & ~r_s_d;
         r_fall <= ~w_s & r_s_d;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_w_cnt_nxt      = r_w_cnt;
      w_p_cnt_nxt      = r_p_cnt;
      w_width_nxt      = r_width;
      w_period_nxt     = r_period;
      w_valid_nxt      = 1'b0;
      w_timeout_nxt    = r_timeout;
      w_meas_count_nxt = r_meas_count;

      if (!bus.enable) begin
         w_state_nxt   = S_IDLE;
         w_timeout_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_rise) begin
                  w_state_nxt = S_HIGH;
                  w_w_cnt_nxt = C_ONE;
                  w_p_cnt_nxt = C_ONE;
               end
            end
            S_HIGH: begin
               if (r_p_cnt == C_TIMEOUT) begin
                  w_state_nxt   = S_IDLE;
                  w_timeout_nxt = 1'b1;
               end else if (r_fall) begin
                  w_state_nxt = S_LOW;
                  w_p_cnt_nxt = r_p_cnt + C_ONE;
               end else begin
                  w_w_cnt_nxt = r_w_cnt + C_ONE;
                  w_p_cnt_nxt = r_p_cnt + C_ONE;
               end
            end
            S_LOW: begin
               // A rise landing on the timeout cycle still completes the measurement.
               if (r_rise) begin
                  w_state_nxt      = S_HIGH;
                  w_width_nxt      = r_w_cnt;
                  w_period_nxt     = r_p_cnt;
                  w_valid_nxt      = 1'b1;
                  w_timeout_nxt    = 1'b0;
                  w_meas_count_nxt = r_meas_count + 16'd1;
                  w_w_cnt_nxt      = C_ONE;
                  w_p_cnt_nxt      = C_ONE;
               end else if (r_p_cnt == C_TIMEOUT) begin
                  w_state_nxt   = S_IDLE;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_p_cnt_nxt = r_p_cnt + C_ONE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_w_cnt      <= '0;
         r_p_cnt      <= '0;
         r_width      <= '0;
         r_period     <= '0;
         r_valid      <= 1'b0;
         r_timeout    <= 1'b0;
         r_meas_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_w_cnt      <= w_w_cnt_nxt;
         r_p_cnt      <= w_p_cnt_nxt;
         r_width      <= w_width_nxt;
         r_period     <= w_period_nxt;
         r_valid      <= w_valid_nxt;
         r_timeout    <= w_timeout_nxt;
         r_meas_count <= w_meas_count_nxt;
      end
   end

   assign bus.width      = r_width;
   assign bus.period     = r_period;
   assign bus.valid      = r_valid;
   assign bus.timeout    = r_timeout;
   assign bus.meas_count = r_meas_count;
endmodule

// File: tb/tb_pulse_capture.sv
// Directed bench for pulse_capture: pulse trains, PWM sweep, stuck input, minimum pulses,
// enable gating and asynchronous reset, all against hand-computed expectations.
module tb_pulse_capture;
   localparam int CNT_W       = 16;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 1000;
   // Cycle index at which valid is seen, relative to the negedge where pulse_in was raised.
   localparam int LAT         = SYNC_STAGES + 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pulse_capture_if #(.CNT_W(CNT_W)) bus ();

   pulse_capture #(
      .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int   v_w[$];
   int   v_p[$];
   int   v_c[$];
   int   v_t[$];
   int   rise_q[$];
   int   to_cyc = -1;
   logic to_d   = 1'b0;

   always @(negedge clk) begin
      if (bus.valid === 1'b1) begin
         v_w.push_back(int'(bus.width));
         v_p.push_back(int'(bus.period));
         v_c.push_back(cyc);
         v_t.push_back(int'(bus.timeout));
      end
      if (bus.timeout === 1'b1 && !to_d) to_cyc = cyc;
      to_d = (bus.timeout === 1'b1);
   end

   task automatic chk_val(input string tag, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic clear_log();
      v_w.delete(); v_p.delete(); v_c.delete(); v_t.delete();
      rise_q.delete();
      to_cyc = -1;
   endtask

   task automatic drive(input logic v, input int n);
      if (v && !bus.pulse_in) rise_q.push_back(cyc);
      bus.pulse_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulses(input int h, input int l, input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, h);
         drive(1'b0, l);
      end
   endtask

   task automatic chk_meas(input string tag, input int idx, input int w, input int p);
      if (idx < v_w.size()) begin
         chk_val({tag, "_w"}, v_w[idx], w);
         chk_val({tag, "_p"}, v_p[idx], p);
         chk_val({tag, "_cyc"}, v_c[idx], rise_q[idx+1] + LAT);
      end
   endtask

   int pwm_w[9] = '{20, 20, 20, 100, 100, 100, 180, 180, 180};
   int duty[3]  = '{20, 100, 180};

   initial begin
      rst          = 1'b1;
      bus.enable   = 1'b0;
      bus.pulse_in = 1'b0;
      repeat (3) @(negedge clk);
      chk_val("rst_width", bus.width, 0);
      chk_val("rst_period", bus.period, 0);
      chk_val("rst_valid", bus.valid, 0);
      chk_val("rst_timeout", bus.timeout, 0);
      chk_val("rst_meas", bus.meas_count, 0);
      rst        = 1'b0;
      bus.enable = 1'b1;
      repeat (5) @(negedge clk);

      // Pulse train H=20, period 100, then idle into timeout
      clear_log();
      pulses(20, 80, 5);
      drive(1'b0, 1000);
      chk_val("train_nvalid", v_w.size(), 4);
      for (int i = 0; i < 4; i++) chk_meas("train", i, 20, 100);
      chk_val("train_meas", bus.meas_count, 4);
      chk_val("train_to_cyc", to_cyc, rise_q[4] + LAT + TIMEOUT);
      chk_val("train_to_lvl", bus.timeout, 1);
      chk_val("train_keep_w", bus.width, 20);
      chk_val("train_keep_p", bus.period, 100);

      // PWM sweep period 200, then the 10th rise stays high
      clear_log();
      for (int d = 0; d < 3; d++) pulses(duty[d], 200 - duty[d], 3);
      drive(1'b1, 1500);
      chk_val("pwm_nvalid", v_w.size(), 9);
      for (int i = 0; i < 9; i++) chk_meas("pwm", i, pwm_w[i], 200);
      if (v_t.size() > 0) chk_val("pwm_to_clr", v_t[0], 0);
      chk_val("pwm_meas", bus.meas_count, 13);
      chk_val("stuck_to_cyc", to_cyc, rise_q[9] + LAT + TIMEOUT);
      chk_val("stuck_to_lvl", bus.timeout, 1);
      chk_val("stuck_keep_w", bus.width, 180);
      chk_val("stuck_keep_p", bus.period, 200);

      // Recovery after timeout: first rise arms, second measures
      clear_log();
      drive(1'b0, 45);
      pulses(5, 45, 2);
      chk_val("rec_nvalid", v_w.size(), 1);
      if (v_w.size() > 0) begin
         chk_val("rec_w", v_w[0], 5);
         chk_val("rec_p", v_p[0], 50);
      end
      chk_val("rec_to", bus.timeout, 0);
      chk_val("rec_meas", bus.meas_count, 14);

      // Minimum pulses; the first rise closes the previous H=5/L=45 cycle
      clear_log();
      pulses(1, 1, 6);
      drive(1'b0, 20);
      chk_val("min_nvalid", v_w.size(), 6);
      if (v_w.size() > 0) begin
         chk_val("min_first_w", v_w[0], 5);
         chk_val("min_first_p", v_p[0], 50);
      end
      for (int i = 1; i < 6; i++) begin
         if (i < v_w.size()) begin
            chk_val("min_w", v_w[i], 1);
            chk_val("min_p", v_p[i], 2);
            chk_val("min_space", v_c[i] - v_c[i-1], 2);
         end
      end
      chk_val("min_meas", bus.meas_count, 20);

      // Enable dropped mid-HIGH; activity while disabled is ignored
      clear_log();
      drive(1'b1, 10);
      bus.enable = 1'b0;
      drive(1'b1, 10);
      drive(1'b0, 30);
      drive(1'b1, 10);
      drive(1'b0, 30);
      chk_val("dis_nvalid", v_w.size(), 1);
      chk_val("dis_w", bus.width, 1);
      chk_val("dis_p", bus.period, 22);
      chk_val("dis_meas", bus.meas_count, 21);
      chk_val("dis_to", bus.timeout, 0);
      bus.enable = 1'b1;
      pulses(30, 70, 2);
      drive(1'b0, 10);
      chk_val("reen_nvalid", v_w.size(), 2);
      if (v_w.size() > 1) begin
         chk_val("reen_w", v_w[1], 30);
         chk_val("reen_p", v_p[1], 100);
      end
      chk_val("reen_meas", bus.meas_count, 22);

      // Timeout is cleared by enable falling
      drive(1'b0, 1100);
      chk_val("en_to_set", bus.timeout, 1);
      bus.enable = 1'b0;
      repeat (2) @(negedge clk);
      chk_val("en_to_clr", bus.timeout, 0);
      chk_val("en_keep_w", bus.width, 30);
      chk_val("en_keep_meas", bus.meas_count, 22);
      bus.enable = 1'b1;
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-HIGH after two valids
      clear_log();
      pulses(10, 40, 2);
      drive(1'b1, 6);
      chk_val("pre_rst_nvalid", v_w.size(), 2);
      #2 rst = 1'b1;
      #1;
      chk_val("arst_width", bus.width, 0);
      chk_val("arst_period", bus.period, 0);
      chk_val("arst_valid", bus.valid, 0);
      chk_val("arst_timeout", bus.timeout, 0);
      chk_val("arst_meas", bus.meas_count, 0);
      bus.pulse_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      clear_log();
      pulses(10, 40, 2);
      drive(1'b0, 10);
      chk_val("post_rst_nvalid", v_w.size(), 1);
      if (v_w.size() > 0) begin
         chk_val("post_rst_w", v_w[0], 10);
         chk_val("post_rst_p", v_p[0], 50);
      end
      chk_val("post_rst_meas", bus.meas_count, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
